control_sequencer: RTL and testbench

- Hardwired control unit that generates, cycle by cycle, the datapath control strobes that the phase-1 benches drive by hand.
- Fetches via PC/MAR/MDR, decodes IR fields, and steps ALU register-register instructions through T0..T6.
- Sits beside DataPath: IR in, every Xin/Xout/ALU-select strobe out.

---
 rtl/control_sequencer_if.sv | 31 +++
 rtl/control_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_control_sequencer.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/control_sequencer_if.sv
// Control strobe bundle between the hardwired sequencer (master) and the datapath (slave).
// IR flows into the sequencer; every bus-drive, load, ALU-select strobe and Run flow out.
interface control_sequencer_if #(
  parameter int NUM_REGS = 16
);
  logic [31:0]         IR;
  logic                PCout, MDRout, Zhighout, Zlowout, HIout, LOout;
  logic                PCin, MARin, MDRin, IRin, Zin, Yin, HIin, LOin;
  logic                IncPC, Read;
  logic [NUM_REGS-1:0] Rin, Rout;
  logic                ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL, MUL, DIV, NEG, NOT;
  logic                Run;

  modport master (
    input  IR,
    output PCout, MDRout, Zhighout, Zlowout, HIout, LOout,
    output PCin, MARin, MDRin, IRin, Zin, Yin, HIin, LOin,
    output IncPC, Read, Rin, Rout,
    output ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL, MUL, DIV, NEG, NOT,
    output Run
  );

  modport slave (
    output IR,
    input  PCout, MDRout, Zhighout, Zlowout, HIout, LOout,
    input  PCin, MARin, MDRin, IRin, Zin, Yin, HIin, LOin,
    input  IncPC, Read, Rin, Rout,
    input  ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL, MUL, DIV, NEG, NOT,
    input  Run
  );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired T0..T6 control sequencer: fetch, decode and ALU register-register execute.
// Optional STEP_MODE_EN adds a Step input that gates each instruction start in T0.
//
// state | meaning
// T0    | PC to MAR, start PC increment
// T1    | memory read, held 1+MEM_WAIT cycles, PC loaded on last cycle
// T2    | MDR to IR
// T3-T6 | execute, sequence chosen by opcode class
// HALT  | stopped, Run low, only Clear exits
module control_sequencer #(
  parameter int MEM_WAIT = 0,
  parameter int NUM_REGS = 16
) (
  input  logic Clock,
  input  logic Clear,
`ifdef STEP_MODE_EN
  input  logic Step,
`endif
  control_sequencer_if.master bus
);

  typedef enum logic [2:0] {T0, T1, T2, T3, T4, T5, T6, HALT} state_t;

  localparam logic [3:0] WAIT_LD = 4'(MEM_WAIT);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [4:0]  opcode;
  logic [3:0]  ra, rb, rc;
  logic [12:0] alu_op;
  logic        is_bin, is_un, is_md, is_halt;
  logic        alu_en, step_go;
  logic        unused_ir;

  assign opcode    = bus.IR[31:27];
  assign ra        = bus.IR[26:23];
  assign rb        = bus.IR[22:19];
  assign rc        = bus.IR[18:15];
  assign unused_ir = ^bus.IR[14:0];

`ifdef STEP_MODE_EN
  assign step_go = Step;
`else
  assign step_go = 1'b1;
`endif

  function automatic logic [NUM_REGS-1:0] onehot(input logic [3:0] idx);
    logic [NUM_REGS-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (i < 16 && idx == i[3:0]) v[i] = 1'b1;
    return v;
  endfunction

  // alu_op bit order: ADD SUB AND OR SHR SHRA SHL ROR ROL MUL DIV NEG NOT (bit 0 = ADD)
  always_comb begin
    alu_op  = '0;
    is_bin  = 1'b0;
    is_un   = 1'b0;
    is_md   = 1'b0;
    is_halt = 1'b0;
    case (opcode)
      5'b00011: begin alu_op[0]  = 1'b1; is_bin = 1'b1; end
      5'b00100: begin alu_op[1]  = 1'b1; is_bin = 1'b1; end
      5'b00101: begin alu_op[2]  = 1'b1; is_bin = 1'b1; end
      5'b00110: begin alu_op[3]  = 1'b1; is_bin = 1'b1; end
      5'b00111: begin alu_op[7]  = 1'b1; is_bin = 1'b1; end
      5'b01000: begin alu_op[8]  = 1'b1; is_bin = 1'b1; end
      5'b01001: begin alu_op[4]  = 1'b1; is_bin = 1'b1; end
      5'b01010: begin alu_op[5]  = 1'b1; is_bin = 1'b1; end
      5'b01011: begin alu_op[6]  = 1'b1; is_bin = 1'b1; end
      5'b01111: begin alu_op[9]  = 1'b1; is_md  = 1'b1; end
      5'b10000: begin alu_op[10] = 1'b1; is_md  = 1'b1; end
      5'b10001: begin alu_op[11] = 1'b1; is_un  = 1'b1; end
      5'b10010: begin alu_op[12] = 1'b1; is_un  = 1'b1; end
      5'b11011: is_halt = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Clear) begin
      state <= T0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    alu_en       = 1'b0;
    bus.PCout    = 1'b0;
    bus.MDRout   = 1'b0;
    bus.Zhighout = 1'b0;
    bus.Zlowout  = 1'b0;
    bus.HIout    = 1'b0;
    bus.LOout    = 1'b0;
    bus.PCin     = 1'b0;
    bus.MARin    = 1'b0;
    bus.MDRin    = 1'b0;
    bus.IRin     = 1'b0;
    bus.Zin      = 1'b0;
    bus.Yin      = 1'b0;
    bus.HIin     = 1'b0;
    bus.LOin     = 1'b0;
    bus.IncPC    = 1'b0;
    bus.Read     = 1'b0;
    bus.Rin      = '0;
    bus.Rout     = '0;
    // Run stays high while Clear is asserted, even if the register still holds HALT
    bus.Run      = !Clear || (state != HALT);
    if (Clear) begin
      case (state)
        T0: if (step_go) begin
          bus.PCout = 1'b1;
          bus.MARin = 1'b1;
          bus.IncPC = 1'b1;
          bus.Zin   = 1'b1;
          state_nxt = T1;
          cnt_nxt   = WAIT_LD;
        end
        T1: begin
          bus.Zlowout = 1'b1;
          bus.Read    = 1'b1;
          bus.MDRin   = 1'b1;
          if (cnt == 4'd0) begin
            bus.PCin  = 1'b1;
            state_nxt = T2;
          end else begin
            cnt_nxt = cnt - 4'd1;
          end
        end
        T2: begin
          bus.MDRout = 1'b1;
          bus.IRin   = 1'b1;
          state_nxt  = T3;
        end
        T3: begin
          if (is_bin || is_un) bus.Rout = onehot(rb);
          if (is_md)           bus.Rout = onehot(ra);
          bus.Yin   = is_bin || is_md;
          bus.Zin   = is_un;
          alu_en    = is_un;
          state_nxt = (is_bin || is_un || is_md) ? T4 : (is_halt ? HALT : T0);
        end
        T4: begin
          if (is_un) begin
            bus.Zlowout = 1'b1;
            bus.Rin     = onehot(ra);
            state_nxt   = T0;
          end else if (is_bin || is_md) begin
            bus.Rout  = is_bin ? onehot(rc) : onehot(rb);
            bus.Zin   = 1'b1;
            alu_en    = 1'b1;
            state_nxt = T5;
          end else begin
            state_nxt = T0;
          end
        end
        T5: begin
          bus.Zlowout = is_bin || is_md;
          if (is_bin) bus.Rin = onehot(ra);
          bus.LOin  = is_md;
          state_nxt = is_md ? T6 : T0;
        end
        T6: begin
          bus.Zhighout = 1'b1;
          bus.HIin     = 1'b1;
          state_nxt    = T0;
        end
        default: state_nxt = HALT;
      endcase
    end
    {bus.NOT, bus.NEG, bus.DIV, bus.MUL, bus.ROL, bus.ROR, bus.SHL,
     bus.SHRA, bus.SHR, bus.OR, bus.AND, bus.SUB, bus.ADD} = alu_en ? alu_op : 13'b0;
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: two instances (MEM_WAIT 0 and 3) checked every cycle
// against a per-instruction strobe-trace model, plus hand-computed literal checkpoints.
module tb_control_sequencer;

  localparam int W1 = 3;

  // Packed strobe vector: [15:0] Rout, [31:16] Rin, [44:32] ALU selects, [45] Run, [61:46] scalars
  localparam logic [61:0] RUN  = 62'd1 << 45;
  localparam logic [61:0] PCO  = 62'd1 << 46;
  localparam logic [61:0] MDRO = 62'd1 << 47;
  localparam logic [61:0] ZHO  = 62'd1 << 48;
  localparam logic [61:0] ZLO  = 62'd1 << 49;
  localparam logic [61:0] PCI  = 62'd1 << 52;
  localparam logic [61:0] MARI = 62'd1 << 53;
  localparam logic [61:0] MDRI = 62'd1 << 54;
  localparam logic [61:0] IRI  = 62'd1 << 55;
  localparam logic [61:0] ZI   = 62'd1 << 56;
  localparam logic [61:0] YI   = 62'd1 << 57;
  localparam logic [61:0] HII  = 62'd1 << 58;
  localparam logic [61:0] LOI  = 62'd1 << 59;
  localparam logic [61:0] INC  = 62'd1 << 60;
  localparam logic [61:0] RD   = 62'd1 << 61;
  localparam logic [31:0] HALT_W = 32'hD800_0000;

  logic clk = 1'b0;
  logic Clear = 1'b0;
  logic step_v = 1'b1;
  always #5 clk = ~clk;

  control_sequencer_if #(.NUM_REGS(16)) bus0();
  control_sequencer_if #(.NUM_REGS(16)) bus1();

  control_sequencer #(.MEM_WAIT(0), .NUM_REGS(16)) dut0 (
    .Clock(clk), .Clear(Clear),
`ifdef STEP_MODE_EN
    .Step(step_v),
`endif
    .bus(bus0));

  control_sequencer #(.MEM_WAIT(W1), .NUM_REGS(16)) dut1 (
    .Clock(clk), .Clear(Clear),
`ifdef STEP_MODE_EN
    .Step(step_v),
`endif
    .bus(bus1));

  logic [61:0] v0, v1;
  assign v0 = {bus0.Read, bus0.IncPC, bus0.LOin, bus0.HIin, bus0.Yin, bus0.Zin, bus0.IRin,
               bus0.MDRin, bus0.MARin, bus0.PCin, bus0.LOout, bus0.HIout, bus0.Zlowout,
               bus0.Zhighout, bus0.MDRout, bus0.PCout, bus0.Run, bus0.NOT, bus0.NEG, bus0.DIV,
               bus0.MUL, bus0.ROL, bus0.ROR, bus0.SHL, bus0.SHRA, bus0.SHR, bus0.OR, bus0.AND,
               bus0.SUB, bus0.ADD, bus0.Rin, bus0.Rout};
  assign v1 = {bus1.Read, bus1.IncPC, bus1.LOin, bus1.HIin, bus1.Yin, bus1.Zin, bus1.IRin,
               bus1.MDRin, bus1.MARin, bus1.PCin, bus1.LOout, bus1.HIout, bus1.Zlowout,
               bus1.Zhighout, bus1.MDRout, bus1.PCout, bus1.Run, bus1.NOT, bus1.NEG, bus1.DIV,
               bus1.MUL, bus1.ROL, bus1.ROR, bus1.SHL, bus1.SHRA, bus1.SHR, bus1.OR, bus1.AND,
               bus1.SUB, bus1.ADD, bus1.Rin, bus1.Rout};

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;

  logic [61:0] q0[$], q1[$];
  logic [31:0] prog[$];
  int          idx[2];
  bit          halted[2];
  bit          ir_load[2];
  logic [31:0] ir_pend[2];
  logic [61:0] cap0[64], cap1[64];

  task automatic chk(input string nm, input logic [61:0] act, input logic [61:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic pushq(input int d, input logic [61:0] v);
    if (d == 0) q0.push_back(v); else q1.push_back(v);
  endtask

  task automatic popq(input int d, output logic [61:0] v);
    if (d == 0) v = q0.pop_front(); else v = q1.pop_front();
  endtask

  function automatic bit emptyq(input int d);
    return (d == 0) ? (q0.size() == 0) : (q1.size() == 0);
  endfunction

  function automatic int alu_idx(input logic [4:0] op);
    case (op)
      5'd3: return 0;   5'd4: return 1;   5'd5: return 2;   5'd6: return 3;
      5'd9: return 4;   5'd10: return 5;  5'd11: return 6;  5'd7: return 7;
      5'd8: return 8;   5'd15: return 9;  5'd16: return 10; 5'd17: return 11;
      5'd18: return 12;
      default: return -1;
    endcase
  endfunction

  function automatic logic [61:0] rout(input int n); return 62'd1 << n; endfunction
  function automatic logic [61:0] rin(input int n);  return 62'd1 << (16 + n); endfunction

  // Execute-phase trace of one instruction, derived from its opcode class
  task automatic push_exec(input int d, input logic [31:0] w);
    int op, ra, rb, rc, k;
    logic [61:0] a;
    op = int'(w[31:27]);
    ra = int'(w[26:23]);
    rb = int'(w[22:19]);
    rc = int'(w[18:15]);
    k  = alu_idx(w[31:27]);
    a  = (k >= 0) ? (62'd1 << (32 + k)) : 62'd0;
    if (op >= 3 && op <= 11) begin
      pushq(d, rout(rb) | YI | RUN);
      pushq(d, rout(rc) | a | ZI | RUN);
      pushq(d, ZLO | rin(ra) | RUN);
    end else if (op == 17 || op == 18) begin
      pushq(d, rout(rb) | a | ZI | RUN);
      pushq(d, ZLO | rin(ra) | RUN);
    end else if (op == 15 || op == 16) begin
      pushq(d, rout(ra) | YI | RUN);
      pushq(d, rout(rb) | a | ZI | RUN);
      pushq(d, ZLO | LOI | RUN);
      pushq(d, ZHO | HII | RUN);
    end else begin
      pushq(d, RUN);
      if (op == 27) halted[d] = 1'b1;
    end
  endtask

  task automatic model_step(input int d, input logic clr, output logic [61:0] e);
    logic [31:0] w;
    if (!clr) begin
      e = RUN;
      if (d == 0) q0.delete(); else q1.delete();
      halted[d] = 1'b0;
      return;
    end
    if (emptyq(d)) begin
      if (halted[d]) begin
        e = '0;
        return;
      end
`ifdef STEP_MODE_EN
      if (!step_v) begin
        e = RUN;
        return;
      end
`endif
      pushq(d, PCO | MARI | INC | ZI | RUN);
      for (int k = 0; k < ((d == 0) ? 0 : W1); k++) pushq(d, ZLO | RD | MDRI | RUN);
      pushq(d, ZLO | RD | MDRI | PCI | RUN);
      pushq(d, MDRO | IRI | RUN);
    end
    popq(d, e);
    if ((e & IRI) != 0) begin
      w = (idx[d] < prog.size()) ? prog[idx[d]] : HALT_W;
      idx[d]++;
      ir_pend[d] = w;
      ir_load[d] = 1'b1;
      push_exec(d, w);
    end
  endtask

  task automatic cycle(input logic clr);
    logic [61:0] e;
    @(negedge clk);
    Clear = clr;
    if (ir_load[0]) begin bus0.IR = ir_pend[0]; ir_load[0] = 1'b0; end
    if (ir_load[1]) begin bus1.IR = ir_pend[1]; ir_load[1] = 1'b0; end
    #1;
    model_step(0, clr, e);
    chk("trace_w0", v0, e);
    model_step(1, clr, e);
    chk("trace_w3", v1, e);
    if (cyc < 64) begin
      cap0[cyc] = v0;
      cap1[cyc] = v1;
    end
    cyc++;
  endtask

  task automatic start_prog();
    q0.delete();
    q1.delete();
    for (int d = 0; d < 2; d++) begin
      idx[d]     = 0;
      halted[d]  = 1'b0;
      ir_load[d] = 1'b0;
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [4:0]  ops[14];
    ops = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11,
            5'd15, 5'd16, 5'd17, 5'd18, 5'd26};
    w = $urandom;
    if ($urandom_range(0, 7) != 0) w[31:27] = ops[$urandom_range(0, 13)];
    else if (w[31:27] == 5'd27) w[31:27] = 5'd31;
    return w;
  endfunction

  initial begin
    bus0.IR = '0;
    bus1.IR = '0;

    // Directed: and, not, mul, div, halt
    start_prog();
    prog = '{32'h2891_8000, 32'h9338_0000, 32'h79A0_0000, 32'h81A0_0000, HALT_W};
    cycle(1'b0);
    cycle(1'b0);
    cyc = 0;
    for (int c = 0; c < 60; c++) cycle(1'b1);
    chk("lit_t0_first",   cap0[0],  PCO | MARI | INC | ZI | RUN);
    chk("lit_and_t3",     cap0[3],  (62'd1 << 2) | YI | RUN);
    chk("lit_and_t4",     cap0[4],  (62'd1 << 3) | (62'd1 << 34) | ZI | RUN);
    chk("lit_and_t5",     cap0[5],  ZLO | (62'd1 << 17) | RUN);
    chk("lit_and_next",   cap0[6],  PCO | MARI | INC | ZI | RUN);
    chk("lit_not_t3",     cap0[9],  (62'd1 << 7) | (62'd1 << 44) | ZI | RUN);
    chk("lit_not_t4",     cap0[10], ZLO | (62'd1 << 22) | RUN);
    chk("lit_mul_t3",     cap0[14], (62'd1 << 3) | YI | RUN);
    chk("lit_mul_t6",     cap0[17], ZHO | HII | RUN);
    chk("lit_w3_t1_wait", cap1[1],  ZLO | RD | MDRI | RUN);
    chk("lit_w3_t1_wait", cap1[3],  ZLO | RD | MDRI | RUN);
    chk("lit_w3_t1_last", cap1[4],  ZLO | RD | MDRI | PCI | RUN);
    chk("lit_w3_t2",      cap1[5],  MDRO | IRI | RUN);
    chk("lit_halt_w0",    v0, 62'd0);
    chk("lit_halt_w3",    v1, 62'd0);

    // Abort: Clear low during T4 of add on the MEM_WAIT=0 instance
    start_prog();
    prog = '{32'h1891_8000, HALT_W};
    cycle(1'b0);
    cyc = 0;
    for (int c = 0; c < 30; c++) cycle(c == 4 ? 1'b0 : 1'b1);
    chk("lit_abort_clear", cap0[4], RUN);
    chk("lit_abort_t0",    cap0[5], PCO | MARI | INC | ZI | RUN);
    chk("lit_abort_w3",    cap1[5], PCO | MARI | INC | ZI | RUN);

    // Randomized programs with occasional mid-stream resets
    for (int r = 0; r < 4; r++) begin
      start_prog();
      prog.delete();
      for (int i = 0; i < 25; i++) prog.push_back(rand_instr());
      prog.push_back(HALT_W);
      cycle(1'b0);
      cyc = 100;
      for (int c = 0; c < 320; c++) begin
`ifdef STEP_MODE_EN
        step_v = ($urandom_range(0, 3) != 0);
`endif
        cycle(($urandom_range(0, 39) != 0) ? 1'b1 : 1'b0);
      end
    end

`ifdef STEP_MODE_EN
    // Step low five cycles, one pulse, then idle again in T0
    start_prog();
    prog = '{32'h1891_8000, 32'h1891_8000};
    step_v = 1'b0;
    cycle(1'b0);
    cyc = 0;
    for (int c = 0; c < 25; c++) begin
      step_v = (c == 5);
      cycle(1'b1);
    end
    chk("lit_step_idle", cap0[2], RUN);
    chk("lit_step_go",   cap0[5], PCO | MARI | INC | ZI | RUN);
    chk("lit_step_stop", cap0[12], RUN);
    step_v = 1'b1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
